// File: rtl/muladd_test_harness_if.sv
// Signal bundle between the mul-add test harness and its environment: serial
// stimulus/result streams, run status, and the operand/result bus of the DUT.
interface muladd_test_harness_if;
  // sin is sampled only on cycles where sin_valid is high; sout carries a
  // result bit only on cycles where sout_valid is high and is 0 otherwise.
  // Neither stream has backpressure.
  logic        sin;
  logic        sin_valid;
  logic        start;
  logic        sout;
  logic        sout_valid;
  logic        busy;
  logic        done;
  logic        mismatch;
  logic [8:0]  a0, a1, a2, a3;
  logic [8:0]  b0, b1, b2, b3;
  logic [3:0]  addsub;
  logic        is_signed;
  logic [53:0] c;
  logic [53:0] z;
  logic [2:0]  state_dbg;

  modport master (
    output sin, sin_valid, start, z,
    input  sout, sout_valid, busy, done, mismatch,
    input  a0, a1, a2, a3, b0, b1, b2, b3, addsub, is_signed, c, state_dbg
  );

  modport slave (
    input  sin, sin_valid, start, z,
    output sout, sout_valid, busy, done, mismatch,
    output a0, a1, a2, a3, b0, b1, b2, b3, addsub, is_signed, c, state_dbg
  );
endinterface

// File: rtl/muladd_test_harness.sv
// Serial-loaded stimulus harness for a 4-lane mul-add DUT: shifts in a 131-bit frame,
// applies it, waits SETTLE_CYCLES, captures z and shifts it out. Optional golden check: MULADD_HARNESS_CHECK_EN.
module muladd_test_harness #(
  parameter int SETTLE_CYCLES = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  muladd_test_harness_if.slave bus
);
  localparam int FRAME_W = 131;
  localparam int Z_W     = 54;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETTLE    = 3'd1,
    CAPTURE   = 3'd2,
    SHIFT_OUT = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t               state;
  logic [FRAME_W-1:0]   frame;
  logic [FRAME_W-1:0]   applied;
  logic [7:0]           bit_cnt;
  logic [7:0]           settle_cnt;
  logic [5:0]           out_cnt;
  logic [Z_W-1:0]       z_cap;
  logic                 sout_q;
  logic                 sout_valid_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 frame_full;
  logic                 accept;

  assign frame_full = (bit_cnt == 8'(FRAME_W));
  assign accept     = (state == IDLE) && bus.start && frame_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      frame        <= '0;
      applied      <= '0;
      bit_cnt      <= '0;
      settle_cnt   <= '0;
      out_cnt      <= '0;
      z_cap        <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // First-shifted bit lands in bit 0 once the frame is full.
          if (bus.sin_valid) begin
            frame <= {bus.sin, frame[FRAME_W-1:1]};
            if (!frame_full) bit_cnt <= bit_cnt + 8'd1;
          end
          if (accept) begin
            applied    <= frame;
            busy_q     <= 1'b1;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == 8'(SETTLE_CYCLES - 1)) state <= CAPTURE;
          else settle_cnt <= settle_cnt + 8'd1;
        end
        CAPTURE: begin
          z_cap        <= bus.z;
          sout_q       <= bus.z[0];
          sout_valid_q <= 1'b1;
          out_cnt      <= '0;
          state        <= SHIFT_OUT;
        end
        SHIFT_OUT: begin
          if (out_cnt == 6'(Z_W - 1)) begin
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            done_q       <= 1'b1;
            state        <= DONE;
          end else begin
            out_cnt <= out_cnt + 6'd1;
            sout_q  <= z_cap[out_cnt + 6'd1];
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          bit_cnt <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MULADD_HARNESS_CHECK_EN
  logic [Z_W-1:0] expected;
  logic           mismatch_q;

  // 9x9 products always fit in 18 bits, so extending the operands to 18 bits
  // first gives the correct product for both signed and unsigned modes.
  always_comb begin
    logic [8:0]     op_a, op_b;
    logic [17:0]    ext_a, ext_b, prod;
    logic [Z_W-1:0] prod_ext;
    expected = applied[FRAME_W-1:77];
    op_a     = '0;
    op_b     = '0;
    ext_a    = '0;
    ext_b    = '0;
    prod     = '0;
    prod_ext = '0;
    for (int i = 0; i < 4; i++) begin
      op_a     = applied[i*9 +: 9];
      op_b     = applied[36 + i*9 +: 9];
      ext_a    = applied[76] ? {{9{op_a[8]}}, op_a} : {9'b0, op_a};
      ext_b    = applied[76] ? {{9{op_b[8]}}, op_b} : {9'b0, op_b};
      prod     = ext_a * ext_b;
      prod_ext = applied[76] ? {{36{prod[17]}}, prod} : {36'b0, prod};
      expected = applied[72 + i] ? (expected - prod_ext) : (expected + prod_ext);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mismatch_q <= 1'b0;
    else if (accept) mismatch_q <= 1'b0;
    else if (state == CAPTURE) mismatch_q <= (bus.z != expected);
  end

  assign bus.mismatch = mismatch_q;
`else
  assign bus.mismatch = 1'b0;
`endif

  assign bus.a0         = applied[8:0];
  assign bus.a1         = applied[17:9];
  assign bus.a2         = applied[26:18];
  assign bus.a3         = applied[35:27];
  assign bus.b0         = applied[44:36];
  assign bus.b1         = applied[53:45];
  assign bus.b2         = applied[62:54];
  assign bus.b3         = applied[71:63];
  assign bus.addsub     = applied[75:72];
  assign bus.is_signed  = applied[76];
  assign bus.c          = applied[130:77];
  assign bus.sout       = sout_q;
  assign bus.sout_valid = sout_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.state_dbg  = state;
endmodule
